// File: rtl/mem_arbiter_if.sv
// Bundle of requester, RAM and debug signals for the two-port memory arbiter.
// The arbiter takes the slave view; requesters, the RAM model and checkers take the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    // Port A (CPU)
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    // Port B (boot loader / DMA)
    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    // RAM side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_we;
    logic [DATA_W-1:0] mem_data_out;

    // Internal state made visible for checkers
    logic [7:0]        dbg_wait_cnt;
    logic              dbg_last_b;

    // Handshake: a request stays asserted until the same-cycle X_gnt; an access
    // is taken at the posedge that ends a cycle with X_req && X_gnt. A granted
    // read returns X_rvalid for exactly the following cycle, with X_rdata.
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_addr, mem_data_in, mem_we,
        input  mem_data_out,
        output dbg_wait_cnt, dbg_last_b
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_addr, mem_data_in, mem_we,
        output mem_data_out,
        input  dbg_wait_cnt, dbg_last_b
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM (one access per clock).
// Define MEM_ARB_RR_EN for round-robin contention; otherwise fixed A priority with a B starvation guard.
module mem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("mem_arbiter: MAX_WAIT must be in 1..255");
    end

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    owner_t           last_owner_q, last_owner_d;
    logic [CNT_W-1:0] wait_cnt_q,   wait_cnt_d;
    logic             a_rvalid_q,   a_rvalid_d;
    logic             b_rvalid_q,   b_rvalid_d;

    logic             a_gnt;
    logic             b_gnt;
    logic             b_wins;

    // Grant decision; reset gates everything so nothing is taken while it is high
    always_comb begin
        a_gnt  = 1'b0;
        b_gnt  = 1'b0;
        b_wins = 1'b0;
        if (!reset) begin
            if (bus.a_req && bus.b_req) begin
`ifdef MEM_ARB_RR_EN
                b_wins = (last_owner_q == OWNER_A);
`else
                b_wins = (wait_cnt_q == MAX_WAIT_C);
`endif
                a_gnt = !b_wins;
                b_gnt = b_wins;
            end else begin
                a_gnt = bus.a_req;
                b_gnt = bus.b_req;
            end
        end
    end

    // RAM steering: idle cycles present port A's address with writes disabled
    always_comb begin
        bus.mem_addr    = bus.a_addr;
        bus.mem_data_in = bus.a_wdata;
        bus.mem_we      = 1'b0;
        if (b_gnt) begin
            bus.mem_addr    = bus.b_addr;
            bus.mem_data_in = bus.b_wdata;
            bus.mem_we      = bus.b_we;
        end else if (a_gnt) begin
            bus.mem_we      = bus.a_we;
        end
    end

    always_comb begin
        a_rvalid_d   = a_gnt && !bus.a_we;
        b_rvalid_d   = b_gnt && !bus.b_we;

        last_owner_d = last_owner_q;
        if (a_gnt) begin
            last_owner_d = OWNER_A;
        end else if (b_gnt) begin
            last_owner_d = OWNER_B;
        end

`ifdef MEM_ARB_RR_EN
        wait_cnt_d = '0;
`else
        // Counts consecutive cycles B was asking but lost; saturates at MAX_WAIT
        wait_cnt_d = '0;
        if (bus.b_req && !b_gnt) begin
            wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q <= OWNER_B;
            wait_cnt_q   <= '0;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
            wait_cnt_q   <= wait_cnt_d;
            a_rvalid_q   <= a_rvalid_d;
            b_rvalid_q   <= b_rvalid_d;
        end
    end

    assign bus.a_gnt        = a_gnt;
    assign bus.b_gnt        = b_gnt;
    assign bus.a_rvalid     = a_rvalid_q;
    assign bus.b_rvalid     = b_rvalid_q;
    // Both read buses share the RAM output; rvalid says whose data it is
    assign bus.a_rdata      = bus.mem_data_out;
    assign bus.b_rdata      = bus.mem_data_out;
    assign bus.dbg_wait_cnt = wait_cnt_q;
    assign bus.dbg_last_b   = (last_owner_q == OWNER_B);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter for the 4096x8 single-port synchronous RAM.
  - Port A: CPU fetch/data path.
  - Port B: boot loader / DMA that fills or inspects memory.
- Grants at most one access per clock, steers address, write data and write enable to the RAM, and returns read data with a valid strobe.
- Sits between the requesters and the RAM; the RAM is unchanged.

Parameters:
- ADDR_W, 12, address width; RAM depth is 2**ADDR_W.
- DATA_W, 8, data width.
- MAX_WAIT, 8, consecutive denied cycles after which port B is force-granted (starvation guard, fixed-priority mode only). Legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- a_req  in  1  port A access request; held until a_gnt.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  port A request accepted this cycle (combinational).
- a_rvalid  out  1  port A read data valid (registered).
- a_rdata  out  DATA_W  port A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- mem_addr  out  ADDR_W  RAM address.
- mem_data_in  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_data_out  in  DATA_W  RAM registered read data.

Behaviour:
- Reset, asserted asynchronously:
  - a_rvalid = b_rvalid = 0.
  - Wait counter = 0; last-owner = B.
  - a_gnt = b_gnt = mem_we = 0 while reset is high (gated combinationally).
  - Nothing is granted in the first cycle reset is high. A request pending at reset is dropped, and the requester must keep req high to retry.
- Grant (combinational, one grant maximum per cycle):
  - Neither req: no grant, mem_we = 0, mem_addr = a_addr.
  - Only one req: that port is granted.
  - Both req, fixed-priority mode: A wins unless the wait counter equals MAX_WAIT, in which case B wins.
- Mux:
  - mem_addr, mem_data_in and mem_we come from the granted port.
  - mem_we = granted port's we; 0 if nothing is granted.
- Wait counter, updated on posedge:
  - Increments when b_req = 1 and b_gnt = 0, saturating at MAX_WAIT.
  - Clears to 0 on b_gnt or when b_req = 0.
- Read latency: a granted read in cycle N gives X_rvalid = 1 for exactly cycle N+1, with X_rdata = mem_data_out.
- A granted write produces no rvalid. It updates the RAM at the posedge ending cycle N.
- Back-to-back: a port may be granted every cycle. rvalid pulses are then contiguous, and each corresponds to the grant one cycle earlier.
- Read data routing: a_rdata and b_rdata are both wired to mem_data_out. Each is meaningful only while its own rvalid is high.
- Read-after-write to the same address in consecutive cycles returns the new data, since the RAM write completes before the next read.
- Simultaneous A-write and B-read to the same address in the same cycle: A is granted and B is stalled; B then reads the new data.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined (round-robin mode): on contention, the port that did not own the previous grant wins.
  - Last-owner is updated on every grant.
  - The wait counter and MAX_WAIT are unused; the counter is held at 0.
- Undefined: fixed priority with the MAX_WAIT starvation guard, as described in Behaviour.

Test Plan:
- Single A write then read: A writes 0x5A to 0x010, then reads 0x010 → a_gnt each cycle; a_rvalid one cycle after the read with a_rdata = 0x5A; b_rvalid stays 0.
- Contention, fixed priority (MAX_WAIT = 8): A reads every cycle while B holds a read of 0x020 (preloaded 0x33) → B denied 8 cycles, b_gnt in cycle 9, b_rvalid in cycle 10 with 0x33, then A resumes.
- Contention, MEM_ARB_RR_EN defined: both ports request continuously → grants alternate A, B, A, B… (reset last-owner = B, so A first); each rvalid arrives one cycle after its grant.
- Back-to-back B reads of 0x000..0x003 holding 0x10, 0x14, 0x04, 0x09 → four contiguous b_rvalid cycles returning data in order.
- Reset mid-operation: raise reset while A has a read granted → a_rvalid = 0 immediately and no gnt during reset; the RAM contents from earlier writes are preserved.
- Same-address conflict: A writes 0xFF to 0x100 while B reads 0x100 in the same cycle → A granted first; B granted next cycle and reads 0xFF.
